system_bus_fabric: RTL and testbench

Parametrised successor to the fixed two-way memory/IO system bus. It routes single CPU load/store transactions to one of NUM_DEV peripherals selected by upper address bits. Each device gets a req/ack handshake, so devices may insert wait states. The fabric also reports decode errors and timeouts, and registers all responses back to the CPU. It sits between processor and RAM/IO/VGA/future peripherals.

---
 rtl/system_bus_fabric.sv | 164 ++++++++++++++++
 tb/tb_system_bus_fabric.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_bus_fabric.sv
// system_bus_fabric: routes single CPU load/store transactions to one of
// NUM_DEV peripherals chosen by an address select field. Each device gets a
// req/ack handshake, so it may insert wait states. The fabric reports decode
// errors and ack timeouts, and every CPU-facing response is registered.
//
// state  | meaning
// IDLE   | waiting for cpu_req; latches the transaction when it arrives
// ACCESS | one-hot dev_req held until the selected device acks or times out
// RESP   | response captured; cpu_ready pulses on the way back to IDLE

module system_bus_fabric #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DEV    = 4,
    parameter int SEL_MSB    = 31,
    parameter int TIMEOUT    = 15,
    localparam int SEL_W     = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cpu_req,
    input  logic [ADDR_WIDTH-1:0]         cpu_addr,
    input  logic                          cpu_write_en,
    input  logic [DATA_WIDTH-1:0]         cpu_write_data,
    input  logic [2:0]                    cpu_read_type,
    output logic                          cpu_ready,
    output logic [DATA_WIDTH-1:0]         cpu_read_data,
    output logic                          cpu_error,
    output logic [SEL_W-1:0]              cpu_device_id,
    output logic [NUM_DEV-1:0]            dev_req,
    output logic [ADDR_WIDTH-1:0]         dev_addr,
    output logic                          dev_write_en,
    output logic [DATA_WIDTH-1:0]         dev_write_data,
    output logic [2:0]                    dev_read_type,
    input  logic [NUM_DEV-1:0]            dev_ack,
    input  logic [NUM_DEV*DATA_WIDTH-1:0] dev_read_data
);

    localparam int SEL_LSB = SEL_MSB - SEL_W + 1;
    // One extra bit so the count of 16 devices still fits for the range check.
    localparam logic [SEL_W:0] NUM_DEV_L = (SEL_W + 1)'(NUM_DEV);
    localparam logic [ADDR_WIDTH-1:0] SEL_MASK =
        {{(ADDR_WIDTH - SEL_W){1'b0}}, {SEL_W{1'b1}}} << SEL_LSB;
    // When the timeout is disabled the counter just free-runs and is never compared.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_L = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q;
    logic [SEL_W-1:0]        idx_q;
    logic [NUM_DEV-1:0]      dev_req_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [2:0]              rtype_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic                    ready_q;

    logic [SEL_W-1:0]        sel_idx_d;
    logic                    sel_valid_d;
    logic [NUM_DEV-1:0]      req_onehot_d;
    logic                    ack_sel_d;
    logic [DATA_WIDTH-1:0]   rdata_sel_d;
    logic [CNT_W-1:0]        cnt_d;

    // Decode the incoming select field and mux the latched device's ack/data.
    always_comb begin
        sel_idx_d    = cpu_addr[SEL_MSB -: SEL_W];
        sel_valid_d  = ({1'b0, sel_idx_d} < NUM_DEV_L);
        req_onehot_d = '0;
        ack_sel_d    = 1'b0;
        rdata_sel_d  = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            req_onehot_d[i] = (sel_idx_d == SEL_W'(i));
            if (idx_q == SEL_W'(i)) begin
                ack_sel_d   = dev_ack[i];
                rdata_sel_d = dev_read_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        cnt_d = cnt_q + CNT_W'(1);
    end

    // Transaction FSM with all CPU- and device-facing outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            dev_req_q <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rtype_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        idx_q   <= sel_idx_d;
                        addr_q  <= cpu_addr & ~SEL_MASK;
                        we_q    <= cpu_write_en;
                        wdata_q <= cpu_write_data;
                        rtype_q <= cpu_read_type;
                        if (sel_valid_d) begin
                            dev_req_q <= req_onehot_d;
                            cnt_q     <= '0;
                            state_q   <= ACCESS;
                        end else begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state_q <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // An ack on the expiry edge is checked first, so it wins.
                    if (ack_sel_d) begin
                        rdata_q   <= rdata_sel_d;
                        err_q     <= 1'b0;
                        dev_req_q <= '0;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                        if ((TIMEOUT != 0) && (cnt_d == TIMEOUT_L)) begin
                            dev_req_q <= '0;
                            rdata_q   <= '0;
                            err_q     <= 1'b1;
                            state_q   <= RESP;
                        end
                    end
                end
                RESP: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    dev_req_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ready      = ready_q;
    assign cpu_read_data  = rdata_q;
    assign cpu_error      = err_q;
    assign cpu_device_id  = idx_q;
    assign dev_req        = dev_req_q;
    assign dev_addr       = addr_q;
    assign dev_write_en   = we_q;
    assign dev_write_data = wdata_q;
    assign dev_read_type  = rtype_q;

endmodule

// File: tb/tb_system_bus_fabric.sv
// Directed bench for system_bus_fabric. Instance A: 4 devices, timeout 15.
// Instance B: 3 devices (for decode errors), timeout 4. Both select on [29:28].

module tb_system_bus_fabric;

    logic clock;
    logic reset;

    // Instance A
    logic         a_cpu_req;
    logic [31:0]  a_cpu_addr;
    logic         a_cpu_write_en;
    logic [31:0]  a_cpu_write_data;
    logic [2:0]   a_cpu_read_type;
    logic         a_cpu_ready;
    logic [31:0]  a_cpu_read_data;
    logic         a_cpu_error;
    logic [1:0]   a_cpu_device_id;
    logic [3:0]   a_dev_req;
    logic [31:0]  a_dev_addr;
    logic         a_dev_write_en;
    logic [31:0]  a_dev_write_data;
    logic [2:0]   a_dev_read_type;
    logic [3:0]   a_dev_ack;
    logic [127:0] a_dev_read_data;

    // Instance B
    logic         b_cpu_req;
    logic [31:0]  b_cpu_addr;
    logic         b_cpu_write_en;
    logic [31:0]  b_cpu_write_data;
    logic [2:0]   b_cpu_read_type;
    logic         b_cpu_ready;
    logic [31:0]  b_cpu_read_data;
    logic         b_cpu_error;
    logic [1:0]   b_cpu_device_id;
    logic [2:0]   b_dev_req;
    logic [31:0]  b_dev_addr;
    logic         b_dev_write_en;
    logic [31:0]  b_dev_write_data;
    logic [2:0]   b_dev_read_type;
    logic [2:0]   b_dev_ack;
    logic [95:0]  b_dev_read_data;

    int checks;
    int failures;

    system_bus_fabric #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_DEV(4), .SEL_MSB(29), .TIMEOUT(15)
    ) dut_a (
        .clock(clock), .reset(reset),
        .cpu_req(a_cpu_req), .cpu_addr(a_cpu_addr), .cpu_write_en(a_cpu_write_en),
        .cpu_write_data(a_cpu_write_data), .cpu_read_type(a_cpu_read_type),
        .cpu_ready(a_cpu_ready), .cpu_read_data(a_cpu_read_data), .cpu_error(a_cpu_error),
        .cpu_device_id(a_cpu_device_id), .dev_req(a_dev_req), .dev_addr(a_dev_addr),
        .dev_write_en(a_dev_write_en), .dev_write_data(a_dev_write_data),
        .dev_read_type(a_dev_read_type), .dev_ack(a_dev_ack), .dev_read_data(a_dev_read_data)
    );

    system_bus_fabric #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_DEV(3), .SEL_MSB(29), .TIMEOUT(4)
    ) dut_b (
        .clock(clock), .reset(reset),
        .cpu_req(b_cpu_req), .cpu_addr(b_cpu_addr), .cpu_write_en(b_cpu_write_en),
        .cpu_write_data(b_cpu_write_data), .cpu_read_type(b_cpu_read_type),
        .cpu_ready(b_cpu_ready), .cpu_read_data(b_cpu_read_data), .cpu_error(b_cpu_error),
        .cpu_device_id(b_cpu_device_id), .dev_req(b_dev_req), .dev_addr(b_dev_addr),
        .dev_write_en(b_dev_write_en), .dev_write_data(b_dev_write_data),
        .dev_read_type(b_dev_read_type), .dev_ack(b_dev_ack), .dev_read_data(b_dev_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_cpu_req = 0; a_cpu_addr = '0; a_cpu_write_en = 0; a_cpu_write_data = '0;
        a_cpu_read_type = '0; a_dev_ack = '0; a_dev_read_data = '0;
        b_cpu_req = 0; b_cpu_addr = '0; b_cpu_write_en = 0; b_cpu_write_data = '0;
        b_cpu_read_type = '0; b_dev_ack = '0; b_dev_read_data = '0;
        tick();
        tick();
        checks++; if (a_dev_req !== 4'b0000) begin failures++; $display("FAIL reset_dev_req: got %b expected 0000", a_dev_req); end
        checks++; if (a_cpu_ready !== 1'b0) begin failures++; $display("FAIL reset_cpu_ready: got %b expected 0", a_cpu_ready); end
        checks++; if (a_cpu_error !== 1'b0) begin failures++; $display("FAIL reset_cpu_error: got %b expected 0", a_cpu_error); end
        checks++; if (a_cpu_read_data !== 32'h0) begin failures++; $display("FAIL reset_cpu_read_data: got %h expected 0", a_cpu_read_data); end
        checks++; if (a_cpu_device_id !== 2'd0) begin failures++; $display("FAIL reset_device_id: got %0d expected 0", a_cpu_device_id); end
        checks++; if ({a_dev_addr, a_dev_write_en, a_dev_write_data, a_dev_read_type} !== 68'h0) begin failures++; $display("FAIL reset_dev_latched: got %h %b %h %b expected all 0", a_dev_addr, a_dev_write_en, a_dev_write_data, a_dev_read_type); end
        checks++; if ({b_dev_req, b_cpu_ready, b_cpu_error} !== 5'b0) begin failures++; $display("FAIL reset_b_outputs: got %b %b %b expected 0", b_dev_req, b_cpu_ready, b_cpu_error); end
        reset = 1'b0;
        tick();
    endtask

    // Load from dev1, ack on the first ACCESS cycle.
    task automatic test_load();
        a_cpu_req = 1; a_cpu_addr = 32'h1000_0040; a_cpu_write_en = 0; a_cpu_read_type = 3'b010;
        tick();
        a_cpu_req = 0; a_cpu_addr = 32'hFFFF_FFFF;
        checks++; if (a_dev_req !== 4'b0010) begin failures++; $display("FAIL load_dev_req: got %b expected 0010", a_dev_req); end
        checks++; if (a_dev_addr !== 32'h0000_0040) begin failures++; $display("FAIL load_dev_addr: got %h expected 00000040", a_dev_addr); end
        checks++; if (a_cpu_device_id !== 2'd1) begin failures++; $display("FAIL load_device_id: got %0d expected 1", a_cpu_device_id); end
        checks++; if (a_dev_read_type !== 3'b010) begin failures++; $display("FAIL load_read_type: got %b expected 010", a_dev_read_type); end
        checks++; if (a_dev_write_en !== 1'b0) begin failures++; $display("FAIL load_write_en: got %b expected 0", a_dev_write_en); end
        a_dev_ack = 4'b0010;
        a_dev_read_data[32 +: 32] = 32'hDEAD_BEEF;
        a_dev_read_data[0 +: 32]  = 32'h1111_1111;
        tick();
        a_dev_ack = 4'b0000;
        checks++; if (a_dev_req !== 4'b0000) begin failures++; $display("FAIL load_req_drop: got %b expected 0000", a_dev_req); end
        checks++; if (a_cpu_ready !== 1'b0) begin failures++; $display("FAIL load_ready_early: got %b expected 0", a_cpu_ready); end
        tick();
        checks++; if (a_cpu_ready !== 1'b1) begin failures++; $display("FAIL load_ready: got %b expected 1", a_cpu_ready); end
        checks++; if (a_cpu_read_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_read_data: got %h expected deadbeef", a_cpu_read_data); end
        checks++; if (a_cpu_error !== 1'b0) begin failures++; $display("FAIL load_error: got %b expected 0", a_cpu_error); end
        tick();
        checks++; if (a_cpu_ready !== 1'b0) begin failures++; $display("FAIL load_ready_pulse: got %b expected 0", a_cpu_ready); end
        checks++; if (a_cpu_read_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_data_hold: got %h expected deadbeef", a_cpu_read_data); end
    endtask

    // Store to dev0 with five wait cycles.
    task automatic test_store_wait();
        a_cpu_req = 1; a_cpu_addr = 32'h0000_0008; a_cpu_write_en = 1;
        a_cpu_write_data = 32'h1234_5678; a_cpu_read_type = 3'b000;
        tick();
        a_cpu_req = 0; a_cpu_write_en = 0; a_cpu_write_data = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({a_dev_req, a_dev_write_en, a_dev_write_data, a_dev_addr} !== {4'b0001, 1'b1, 32'h1234_5678, 32'h0000_0008}) begin failures++; $display("FAIL store_hold cycle %0d: got %b %b %h %h expected 0001 1 12345678 00000008", i, a_dev_req, a_dev_write_en, a_dev_write_data, a_dev_addr); end
            checks++; if (a_cpu_ready !== 1'b0) begin failures++; $display("FAIL store_ready_early cycle %0d: got %b expected 0", i, a_cpu_ready); end
            tick();
        end
        checks++; if ({a_dev_req, a_dev_write_en, a_dev_write_data} !== {4'b0001, 1'b1, 32'h1234_5678}) begin failures++; $display("FAIL store_hold_cycle6: got %b %b %h expected 0001 1 12345678", a_dev_req, a_dev_write_en, a_dev_write_data); end
        a_dev_ack = 4'b0001;
        a_dev_read_data[0 +: 32] = 32'h0BAD_F00D;
        tick();
        a_dev_ack = 4'b0000;
        checks++; if ({a_dev_req, a_cpu_ready} !== 5'b0) begin failures++; $display("FAIL store_after_ack: got %b %b expected 0000 0", a_dev_req, a_cpu_ready); end
        tick();
        checks++; if ({a_cpu_ready, a_cpu_error} !== 2'b10) begin failures++; $display("FAIL store_ready_err: got %b %b expected 1 0", a_cpu_ready, a_cpu_error); end
        checks++; if (a_cpu_device_id !== 2'd0) begin failures++; $display("FAIL store_device_id: got %0d expected 0", a_cpu_device_id); end
        tick();
    endtask

    // Instance B: a good load to dev2, then an address decoding to absent device 3.
    task automatic test_decode_error();
        b_cpu_req = 1; b_cpu_addr = 32'h2000_0010;
        tick();
        b_cpu_req = 0;
        checks++; if (b_dev_req !== 3'b100) begin failures++; $display("FAIL dec_pre_req: got %b expected 100", b_dev_req); end
        b_dev_ack = 3'b100; b_dev_read_data[64 +: 32] = 32'hA5A5_0001;
        tick();
        b_dev_ack = 3'b000;
        tick();
        checks++; if (b_cpu_read_data !== 32'hA5A5_0001) begin failures++; $display("FAIL dec_pre_data: got %h expected a5a50001", b_cpu_read_data); end
        tick();
        b_cpu_req = 1; b_cpu_addr = 32'h3000_0000;
        tick();
        b_cpu_req = 0;
        checks++; if ({b_dev_req, b_cpu_ready} !== 4'b0) begin failures++; $display("FAIL dec_no_req: got %b %b expected 000 0", b_dev_req, b_cpu_ready); end
        checks++; if (b_cpu_device_id !== 2'd3) begin failures++; $display("FAIL dec_device_id: got %0d expected 3", b_cpu_device_id); end
        tick();
        checks++; if ({b_cpu_ready, b_cpu_error, b_dev_req} !== 5'b11000) begin failures++; $display("FAIL dec_resp: got ready %b err %b req %b expected 1 1 000", b_cpu_ready, b_cpu_error, b_dev_req); end
        checks++; if (b_cpu_read_data !== 32'h0) begin failures++; $display("FAIL dec_read_data: got %h expected 0", b_cpu_read_data); end
        tick();
        checks++; if ({b_cpu_ready, b_cpu_error} !== 2'b01) begin failures++; $display("FAIL dec_hold: got ready %b err %b expected 0 1", b_cpu_ready, b_cpu_error); end
    endtask

    // dev2 never acks while dev0 acks every cycle.
    task automatic test_timeout();
        a_dev_ack = 4'b0001;
        a_dev_read_data[0 +: 32] = 32'h5555_AAAA;
        a_cpu_req = 1; a_cpu_addr = 32'h2000_0100;
        tick();
        a_cpu_req = 0;
        for (int i = 0; i < 15; i++) begin
            checks++; if ({a_dev_req, a_cpu_ready} !== 5'b01000) begin failures++; $display("FAIL to_wait cycle %0d: got req %b ready %b expected 0100 0", i, a_dev_req, a_cpu_ready); end
            tick();
        end
        checks++; if (a_dev_req !== 4'b0000) begin failures++; $display("FAIL to_req_drop: got %b expected 0000", a_dev_req); end
        tick();
        checks++; if ({a_cpu_ready, a_cpu_error} !== 2'b11) begin failures++; $display("FAIL to_resp: got ready %b err %b expected 1 1", a_cpu_ready, a_cpu_error); end
        checks++; if (a_cpu_read_data !== 32'h0) begin failures++; $display("FAIL to_read_data: got %h expected 0", a_cpu_read_data); end
        checks++; if (a_cpu_device_id !== 2'd2) begin failures++; $display("FAIL to_device_id: got %0d expected 2", a_cpu_device_id); end
        a_dev_ack = 4'b0000;
        tick();
    endtask

    // Asynchronous reset inside ACCESS, then a fresh load to dev3.
    task automatic test_reset_mid();
        a_cpu_req = 1; a_cpu_addr = 32'h1000_0020;
        tick();
        a_cpu_req = 0;
        checks++; if (a_dev_req !== 4'b0010) begin failures++; $display("FAIL rst_pre_req: got %b expected 0010", a_dev_req); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({a_dev_req, a_cpu_ready} !== 5'b0) begin failures++; $display("FAIL rst_async_drop: got req %b ready %b expected 0000 0", a_dev_req, a_cpu_ready); end
        checks++; if (a_dev_addr !== 32'h0) begin failures++; $display("FAIL rst_async_addr: got %h expected 0", a_dev_addr); end
        a_dev_ack = 4'b0010;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({a_dev_req, a_cpu_ready} !== 5'b0) begin failures++; $display("FAIL rst_no_ready cycle %0d: got req %b ready %b expected 0000 0", i, a_dev_req, a_cpu_ready); end
        end
        a_dev_ack = 4'b0000;
        a_cpu_req = 1; a_cpu_addr = 32'h3000_0010;
        tick();
        a_cpu_req = 0;
        checks++; if ({a_dev_req, a_dev_addr} !== {4'b1000, 32'h0000_0010}) begin failures++; $display("FAIL rst_fresh_req: got %b %h expected 1000 00000010", a_dev_req, a_dev_addr); end
        a_dev_ack = 4'b1000; a_dev_read_data[96 +: 32] = 32'hCAFE_0003;
        tick();
        a_dev_ack = 4'b0000;
        tick();
        checks++; if ({a_cpu_ready, a_cpu_error, a_cpu_device_id} !== 4'b1011) begin failures++; $display("FAIL rst_fresh_resp: got ready %b err %b id %0d expected 1 0 3", a_cpu_ready, a_cpu_error, a_cpu_device_id); end
        checks++; if (a_cpu_read_data !== 32'hCAFE_0003) begin failures++; $display("FAIL rst_fresh_data: got %h expected cafe0003", a_cpu_read_data); end
        tick();
    endtask

    // Instance B, TIMEOUT=4: ack on the expiry edge, then back-to-back loads.
    task automatic test_back_to_back();
        int c;
        int pulses;
        int first_c;
        int second_c;
        b_cpu_req = 1; b_cpu_addr = 32'h1000_0004;
        tick();
        b_cpu_req = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (b_dev_req !== 3'b010) begin failures++; $display("FAIL edge_wait cycle %0d: got %b expected 010", i, b_dev_req); end
            tick();
        end
        checks++; if (b_dev_req !== 3'b010) begin failures++; $display("FAIL edge_wait_last: got %b expected 010", b_dev_req); end
        b_dev_ack = 3'b010; b_dev_read_data[32 +: 32] = 32'h7777_1111;
        tick();
        b_dev_ack = 3'b000;
        checks++; if (b_dev_req !== 3'b000) begin failures++; $display("FAIL edge_req_drop: got %b expected 000", b_dev_req); end
        tick();
        checks++; if ({b_cpu_ready, b_cpu_error} !== 2'b10) begin failures++; $display("FAIL edge_ack_wins: got ready %b err %b expected 1 0", b_cpu_ready, b_cpu_error); end
        checks++; if (b_cpu_read_data !== 32'h7777_1111) begin failures++; $display("FAIL edge_data: got %h expected 77771111", b_cpu_read_data); end
        tick();

        b_dev_ack = 3'b110;
        b_dev_read_data[32 +: 32] = 32'h0000_D001;
        b_dev_read_data[64 +: 32] = 32'h0000_D002;
        b_cpu_req = 1; b_cpu_addr = 32'h1000_0000;
        c = 0; pulses = 0; first_c = 0; second_c = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            c++;
            if (c == 1) b_cpu_addr = 32'h2000_0000;
            if (c == 4) b_cpu_req = 0;
            if (b_cpu_ready === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    first_c = c;
                    checks++; if (b_cpu_read_data !== 32'h0000_D001) begin failures++; $display("FAIL b2b_data1: got %h expected 0000d001", b_cpu_read_data); end
                end else begin
                    second_c = c;
                    checks++; if ({b_cpu_read_data, b_cpu_device_id} !== {32'h0000_D002, 2'd2}) begin failures++; $display("FAIL b2b_data2: got %h id %0d expected 0000d002 2", b_cpu_read_data, b_cpu_device_id); end
                end
            end
        end
        b_dev_ack = 3'b000;
        checks++; if (pulses !== 2) begin failures++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        checks++; if (first_c !== 3) begin failures++; $display("FAIL b2b_first_latency: got %0d expected 3", first_c); end
        checks++; if (second_c - first_c !== 3) begin failures++; $display("FAIL b2b_spacing: got %0d expected 3", second_c - first_c); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_load();
        test_store_wait();
        test_decode_error();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
